// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller: FSM states, ALU functions,
// datapath mux encodings, instruction classes and base opcodes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {OPA_RS1 = 2'b00, OPA_PC  = 2'b01, OPA_ZERO = 2'b10} opa_sel_e;
  typedef enum logic [1:0] {OPB_RS2 = 2'b00, OPB_IMM = 2'b01, OPB_FOUR = 2'b10} opb_sel_e;
  typedef enum logic [1:0] {WB_ALU  = 2'b00, WB_MEM  = 2'b01, WB_PC4   = 2'b10} wb_sel_e;

  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OP_IMM = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_JALR   = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_LOAD   = 4'd7,
    CLS_STORE  = 4'd8
  } ins_class_e;

  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;

  // alt selects SUB over ADD and SRA over SRL (instr bit 30)
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I decode: instruction class, ALU function and illegal-encoding
// detection from opcode/funct3/funct7.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output ins_class_e cls,
  output logic       illegal
);

  logic f7_zero_s;
  logic f7_alt_s;

  assign f7_zero_s = (funct7 == 7'b000_0000);
  assign f7_alt_s  = (funct7 == 7'b010_0000);

  // Opcode classification; anything outside the RV32I base set above is illegal
  always_comb begin
    alu_op  = ALU_ADD;
    cls     = CLS_OP;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls    = CLS_OP;
        alu_op = alu_from_f3(funct3, funct7[5]);
        if (f7_zero_s) begin
          illegal = 1'b0;
        end else begin
          illegal = !(f7_alt_s && (funct3 == 3'b000 || funct3 == 3'b101));
        end
      end
      OPC_OP_IMM: begin
        cls = CLS_OP_IMM;
        if (funct3 == 3'b001) begin
          alu_op  = ALU_SLL;
          illegal = !f7_zero_s;
        end else if (funct3 == 3'b101) begin
          alu_op  = alu_from_f3(funct3, funct7[5]);
          illegal = !(f7_zero_s || f7_alt_s);
        end else begin
          alu_op  = alu_from_f3(funct3, 1'b0);
          illegal = 1'b0;
        end
      end
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR: begin
        cls     = CLS_JALR;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 > 3'b010);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch over a req/ack port, decode, then one
// datapath phase per state with registered controls and a memory wait timeout.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_data,
  output logic        ir_we,
  output logic [1:0]  opa_sel,
  output logic [1:0]  opb_sel,
  output logic [3:0]  alu_op,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        trap,
  output logic        mem_err
);

  state_e     state_r;
  logic [6:0] opcode_r;
  logic [6:0] funct7_r;
  logic [2:0] funct3_r;
  logic [4:0] rd_r;
  logic [15:0] wait_cnt_r;
  logic       mem_req_r, mem_we_r, mem_is_data_r;
  opa_sel_e   opa_sel_r;
  opb_sel_e   opb_sel_r;
  alu_op_e    alu_op_r;
  wb_sel_e    wb_sel_r;
  logic       pc_we_r, pc_sel_r, rf_we_r, br_exec_r, trap_r, mem_err_r;

  alu_op_e    dec_alu_s;
  ins_class_e dec_cls_s;
  logic       dec_illegal_s;
  logic       acked_s;
  logic       timeout_s;
  logic       unused_s;

  rv_ctrl_decode u_decode (
    .opcode  (opcode_r),
    .funct3  (funct3_r),
    .funct7  (funct7_r),
    .alu_op  (dec_alu_s),
    .cls     (dec_cls_s),
    .illegal (dec_illegal_s)
  );

  assign acked_s   = mem_req_r & mem_ack;
  assign timeout_s = (MEM_TIMEOUT != 32'd0) && (wait_cnt_r == 16'(MEM_TIMEOUT - 32'd1));
  // The PC register itself lives in the datapath; immediate fields are built there too
  assign unused_s  = ^{instr[24:15], RESET_PC};

  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_is_data = mem_is_data_r;
  assign ir_we       = (state_r == FETCH) & acked_s;
  assign opa_sel     = opa_sel_r;
  assign opb_sel     = opb_sel_r;
  assign alu_op      = alu_op_r;
  assign pc_we       = pc_we_r | ((state_r == MEM) & acked_s & (dec_cls_s == CLS_STORE));
  assign pc_sel      = pc_sel_r | (br_exec_r & br_taken);
  assign rf_we       = rf_we_r;
  assign wb_sel      = wb_sel_r;
  assign state_o     = state_r;
  assign trap        = trap_r;
  assign mem_err     = mem_err_r;

  // Control sequencer: state, registered controls for the state being entered, wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= FETCH;
      opcode_r      <= 7'd0;
      funct7_r      <= 7'd0;
      funct3_r      <= 3'd0;
      rd_r          <= 5'd0;
      wait_cnt_r    <= 16'd0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_is_data_r <= 1'b0;
      opa_sel_r     <= OPA_RS1;
      opb_sel_r     <= OPB_RS2;
      alu_op_r      <= ALU_ADD;
      wb_sel_r      <= WB_ALU;
      pc_we_r       <= 1'b0;
      pc_sel_r      <= 1'b0;
      rf_we_r       <= 1'b0;
      br_exec_r     <= 1'b0;
      trap_r        <= 1'b0;
      mem_err_r     <= 1'b0;
    end else begin
      pc_we_r   <= 1'b0;
      pc_sel_r  <= 1'b0;
      rf_we_r   <= 1'b0;
      br_exec_r <= 1'b0;
      case (state_r)
        FETCH: begin
          if (!mem_req_r) begin
            // first fetch after reset: raise the request
            mem_req_r     <= 1'b1;
            mem_is_data_r <= 1'b0;
            mem_we_r      <= 1'b0;
            wait_cnt_r    <= 16'd0;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            opcode_r  <= instr[6:0];
            rd_r      <= instr[11:7];
            funct3_r  <= instr[14:12];
            funct7_r  <= instr[31:25];
            state_r   <= DECODE;
          end else if (timeout_s) begin
            mem_req_r <= 1'b0;
            mem_err_r <= 1'b1;
            trap_r    <= 1'b1;
            state_r   <= TRAP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        DECODE: begin
          if (dec_illegal_s) begin
            trap_r  <= 1'b1;
            state_r <= TRAP;
          end else begin
            state_r  <= EXEC;
            alu_op_r <= dec_alu_s;
            case (dec_cls_s)
              CLS_OP:    begin opa_sel_r <= OPA_RS1;  opb_sel_r <= OPB_RS2; end
              CLS_LUI:   begin opa_sel_r <= OPA_ZERO; opb_sel_r <= OPB_IMM; end
              CLS_AUIPC: begin opa_sel_r <= OPA_PC;   opb_sel_r <= OPB_IMM; end
              CLS_JAL: begin
                opa_sel_r <= OPA_PC;
                opb_sel_r <= OPB_IMM;
                pc_we_r   <= 1'b1;
                pc_sel_r  <= 1'b1;
              end
              CLS_JALR: begin
                opa_sel_r <= OPA_RS1;
                opb_sel_r <= OPB_IMM;
                pc_we_r   <= 1'b1;
                pc_sel_r  <= 1'b1;
              end
              CLS_BRANCH: begin
                // pc_sel follows br_taken live during EXEC
                opa_sel_r <= OPA_PC;
                opb_sel_r <= OPB_IMM;
                pc_we_r   <= 1'b1;
                br_exec_r <= 1'b1;
              end
              default:   begin opa_sel_r <= OPA_RS1;  opb_sel_r <= OPB_IMM; end
            endcase
          end
        end
        EXEC: begin
          case (dec_cls_s)
            CLS_BRANCH: begin
              state_r       <= FETCH;
              mem_req_r     <= 1'b1;
              mem_is_data_r <= 1'b0;
              mem_we_r      <= 1'b0;
              wait_cnt_r    <= 16'd0;
            end
            CLS_LOAD, CLS_STORE: begin
              state_r       <= MEM;
              mem_req_r     <= 1'b1;
              mem_is_data_r <= 1'b1;
              mem_we_r      <= (dec_cls_s == CLS_STORE);
              wait_cnt_r    <= 16'd0;
            end
            CLS_JAL, CLS_JALR: begin
              state_r  <= WB;
              wb_sel_r <= WB_PC4;
              rf_we_r  <= (rd_r != 5'd0);
            end
            default: begin
              state_r  <= WB;
              wb_sel_r <= WB_ALU;
              rf_we_r  <= (rd_r != 5'd0);
              pc_we_r  <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            if (dec_cls_s == CLS_STORE) begin
              state_r       <= FETCH;
              mem_req_r     <= 1'b1;
              mem_is_data_r <= 1'b0;
              mem_we_r      <= 1'b0;
              wait_cnt_r    <= 16'd0;
            end else begin
              state_r   <= WB;
              mem_req_r <= 1'b0;
              wb_sel_r  <= WB_MEM;
              rf_we_r   <= (rd_r != 5'd0);
              pc_we_r   <= 1'b1;
            end
          end else if (timeout_s) begin
            mem_req_r <= 1'b0;
            mem_err_r <= 1'b1;
            trap_r    <= 1'b1;
            state_r   <= TRAP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        WB: begin
          state_r       <= FETCH;
          mem_req_r     <= 1'b1;
          mem_is_data_r <= 1'b0;
          mem_we_r      <= 1'b0;
          wait_cnt_r    <= 16'd0;
        end
        TRAP: begin
          trap_r    <= 1'b1;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
        default: begin
          trap_r    <= 1'b1;
          mem_req_r <= 1'b0;
          state_r   <= TRAP;
        end
      endcase
    end
  end

endmodule
